// File: rtl/accum_rr_sched_pkg.sv
// Shared types and helpers for the round-robin accumulator scheduler.
package accum_rr_sched_pkg;

  localparam int unsigned STAT_W  = 16;
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit scanning upward from ptr+1, wrapping at n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int unsigned        n);
    pick_t            p;
    logic [IDX_W-1:0] k;
    p = '0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      k = IDX_W'((32'(ptr) + i) % n);
      if (i <= n && !p.found && valid[k]) begin
        p.found = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/accum_rr_sched_if.sv
// Request/response bus between requesters and the accumulator scheduler.
interface accum_rr_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_sum;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum
  );
endinterface

// File: rtl/accum_rr_sched_rr_arbiter.sv
// Round-robin arbiter: pointer register plus combinational one-hot grant.
module rr_arbiter
  import accum_rr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               found
);

  logic [ID_W-1:0]    ptr;
  logic [MAX_REQ-1:0] valid_ext;
  pick_t              pick;
  logic               unused_pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
    pick                   = rr_pick(valid_ext, IDX_W'(ptr), NUM_REQ);
    found                  = pick.found;
    grant_id               = ID_W'(pick.idx);
    grant                  = '0;
    if (pick.found) grant[grant_id] = 1'b1;
  end

  assign unused_pick = ^pick;

  // Pointer starts at the last requester so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= ID_W'(NUM_REQ - 1);
    else if (advance) ptr <= grant_id;
  end

endmodule

// File: rtl/accum_rr_sched.sv
// Shared accumulator sequenced by round-robin grants (IDLE -> ADD -> RESP).
// Define ACCUM_RR_SCHED_STATS_EN to build per-requester saturating grant counters.
module accum_rr_sched
  import accum_rr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  accum_rr_sched_if.slave   bus,
  input  logic              clear,
  output logic [DATA_W-1:0] accum_out,
  input  logic [ID_W-1:0]   stat_sel,
  output logic [STAT_W-1:0] stat_cnt
);

  state_t             state;
  logic [DATA_W-1:0]  accum, operand, operand_sel, sum;
  logic [DATA_W-1:0]  resp_sum;
  logic [ID_W-1:0]    id_q, grant_id, resp_id;
  logic [NUM_REQ-1:0] grant;
  logic               found, advance, resp_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (bus.req_valid),
    .advance  (advance),
    .grant    (grant),
    .grant_id (grant_id),
    .found    (found)
  );

  assign advance        = (state == S_IDLE) && found;
  assign bus.req_ready  = (state == S_IDLE) ? grant : '0;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_id    = resp_id;
  assign bus.resp_sum   = resp_sum;
  assign accum_out      = accum;

  always_comb begin
    operand_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) operand_sel = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  // A clear coincident with ADD zeroes the base before the add.
  assign sum = (clear ? '0 : accum) + operand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      accum      <= '0;
      operand    <= '0;
      id_q       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (clear) accum <= '0;
          if (found) begin
            operand <= operand_sel;
            id_q    <= grant_id;
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          accum      <= sum;
          resp_sum   <= sum;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (clear) accum <= '0;
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ACCUM_RR_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (advance && stat_q[grant_id] != '1) begin
      stat_q[grant_id] <= stat_q[grant_id] + STAT_W'(1);
    end
  end

  assign stat_cnt = (32'(stat_sel) < NUM_REQ) ? stat_q[stat_sel] : '0;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_accum_rr_sched.sv
// Self-checking bench for accum_rr_sched: directed scenarios plus a randomized
// run compared against a transaction-level model of the scheduler.
module tb_accum_rr_sched;
  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = $clog2(NR);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [DW-1:0] accum_out;
  logic [IW-1:0] stat_sel;
  logic [15:0]   stat_cnt;
  int            checks   = 0;
  int            failures = 0;

  accum_rr_sched_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  accum_rr_sched #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .clear     (clear),
    .accum_out (accum_out),
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
  );

  always #5 clk = ~clk;

  function automatic int model_winner(input logic [NR-1:0] v, input int last);
    int c;
    for (int k = 1; k <= NR; k++) begin
      c = (last + k) % NR;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; clear = 1'b0; stat_sel = '0;
    bus.req_valid = '0; bus.req_data = '0; bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stimulus only: request from one requester and wait for its response.
  task automatic issue(input int id, input logic [DW-1:0] d,
                       output logic [IW-1:0] rid, output logic [DW-1:0] rsum, output bit ok);
    int n;
    ok = 1'b0; rid = '0; rsum = '0;
    bus.req_valid[id] = 1'b1;
    bus.req_data[id*DW +: DW] = d;
    n = 0; #1;
    while (bus.req_ready[id] !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    if (n >= 20) return;
    n = 0; #1;
    while (bus.resp_valid !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    rid = bus.resp_id; rsum = bus.resp_sum; ok = (n < 20);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; clear = 1'b0; stat_sel = '0;
    bus.req_valid = '0; bus.req_data = '0; bus.resp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got %b exp 0", bus.resp_valid); end
    checks++; if (accum_out !== 32'd0) begin failures++; $display("FAIL reset_accum got %0h exp 0", accum_out); end
    checks++; if (bus.resp_id !== 2'd0 || bus.resp_sum !== 32'd0) begin failures++; $display("FAIL reset_resp got id=%0d sum=%0h exp 0/0", bus.resp_id, bus.resp_sum); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    bus.req_valid[2] = 1'b1; bus.req_data[2*DW +: DW] = 32'd5; #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL first_grant got %b exp 0100", bus.req_ready); end
    @(negedge clk); bus.req_valid[2] = 1'b0; #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin failures++; $display("FAIL add_cycle got valid=%b ready=%b exp 0/0000", bus.resp_valid, bus.req_ready); end
    @(negedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_sum !== 32'd5) begin failures++; $display("FAIL first_resp got v=%b id=%0d sum=%0d exp 1/2/5", bus.resp_valid, bus.resp_id, bus.resp_sum); end
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic [DW-1:0] exp_sum;
    logic [NR-1:0] exp_rdy;
    do_reset;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = 1'b1; bus.req_data[i*DW +: DW] = DW'(i + 1);
    end
    exp_sum = '0;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_rdy = '0; exp_rdy[k % NR] = 1'b1;
      checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant[%0d] got %b exp %b", k, bus.req_ready, exp_rdy); end
      @(negedge clk); #1;
      checks++; if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rr_add[%0d] got ready=%b valid=%b exp 0000/0", k, bus.req_ready, bus.resp_valid); end
      @(negedge clk); #1;
      exp_sum = exp_sum + DW'((k % NR) + 1);
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== IW'(k % NR) || bus.resp_sum !== exp_sum) begin failures++; $display("FAIL rr_resp[%0d] got v=%b id=%0d sum=%0d exp 1/%0d/%0d", k, bus.resp_valid, bus.resp_id, bus.resp_sum, k % NR, exp_sum); end
      @(negedge clk); #1;
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [IW-1:0] rid; logic [DW-1:0] rs; bit ok;
    do_reset;
    issue(0, 32'hFFFF_FFFE, rid, rs, ok);
    checks++; if (!ok || rs !== 32'hFFFF_FFFE) begin failures++; $display("FAIL wrap_preload got ok=%0d sum=%0h exp 1/fffffffe", ok, rs); end
    issue(1, 32'd3, rid, rs, ok);
    checks++; if (!ok || rid !== 2'd1 || rs !== 32'd1) begin failures++; $display("FAIL wrap_sum got ok=%0d id=%0d sum=%0h exp 1/1/1", ok, rid, rs); end
    #1;
    checks++; if (accum_out !== 32'd1) begin failures++; $display("FAIL wrap_accum got %0h exp 1", accum_out); end
  endtask

  task automatic test_clear;
    logic [IW-1:0] rid; logic [DW-1:0] rs; bit ok;
    do_reset;
    issue(0, 32'd100, rid, rs, ok);
    checks++; if (!ok || rs !== 32'd100) begin failures++; $display("FAIL clear_pre got ok=%0d sum=%0d exp 1/100", ok, rs); end
    bus.resp_ready = 1'b0;
    bus.req_valid[1] = 1'b1; bus.req_data[1*DW +: DW] = 32'd7; #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL clear_grant got %b exp 0010", bus.req_ready); end
    @(negedge clk); bus.req_valid[1] = 1'b0; clear = 1'b1;
    @(negedge clk); clear = 1'b0; #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_sum !== 32'd7 || accum_out !== 32'd7) begin failures++; $display("FAIL clear_in_add got v=%b sum=%0d acc=%0d exp 1/7/7", bus.resp_valid, bus.resp_sum, accum_out); end
    clear = 1'b1;
    @(negedge clk); clear = 1'b0; #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_sum !== 32'd7 || accum_out !== 32'd0) begin failures++; $display("FAIL clear_in_resp got v=%b sum=%0d acc=%0d exp 1/7/0", bus.resp_valid, bus.resp_sum, accum_out); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] d, e;
    d = $urandom; e = $urandom;
    do_reset;
    bus.resp_ready = 1'b0;
    bus.req_valid[3] = 1'b1; bus.req_data[3*DW +: DW] = d; #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL bp_grant got %b exp 1000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[3] = 1'b0; bus.req_valid[0] = 1'b1; bus.req_data[0 +: DW] = e;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3 || bus.resp_sum !== d) begin failures++; $display("FAIL bp_hold[%0d] got v=%b id=%0d sum=%0h exp 1/3/%0h", c, bus.resp_valid, bus.resp_id, bus.resp_sum, d); end
      checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_no_grant[%0d] got %b exp 0000", c, bus.req_ready); end
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_next_grant got %b exp 0001", bus.req_ready); end
    @(negedge clk); bus.req_valid[0] = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_sum !== d + e) begin failures++; $display("FAIL bp_second got v=%b id=%0d sum=%0h exp 1/0/%0h", bus.resp_valid, bus.resp_id, bus.resp_sum, d + e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    do_reset;
    bus.resp_ready = 1'b0;
    bus.req_valid[2] = 1'b1; bus.req_data[2*DW +: DW] = 32'd9;
    @(negedge clk); bus.req_valid[2] = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_sum !== 32'd9) begin failures++; $display("FAIL rst_mid_pre got v=%b sum=%0d exp 1/9", bus.resp_valid, bus.resp_sum); end
    rst_n = 1'b0; #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_id !== 2'd0 || bus.resp_sum !== 32'd0) begin failures++; $display("FAIL rst_mid_resp got v=%b id=%0d sum=%0h exp 0/0/0", bus.resp_valid, bus.resp_id, bus.resp_sum); end
    checks++; if (accum_out !== 32'd0 || bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_mid_acc got acc=%0h ready=%b exp 0/0000", accum_out, bus.req_ready); end
    bus.req_valid = '1; bus.resp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_mid_prio got %b exp 0001", bus.req_ready); end
    bus.req_valid = '0;
    @(negedge clk); #1;
    checks++; if (accum_out !== 32'd0 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_drop got acc=%0h v=%b exp 0/0", accum_out, bus.resp_valid); end
    @(negedge clk);
  endtask

  task automatic test_stats;
    logic [IW-1:0] rid; logic [DW-1:0] rs; bit ok;
    do_reset;
`ifdef ACCUM_RR_SCHED_STATS_EN
    for (int k = 0; k < 3; k++) begin
      issue(1, $urandom, rid, rs, ok);
      checks++; if (!ok) begin failures++; $display("FAIL stats_issue[%0d] got timeout exp response", k); end
    end
    issue(2, $urandom, rid, rs, ok);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    stat_sel = 2'd1; #1;
    checks++; if (stat_cnt !== 16'd3) begin failures++; $display("FAIL stats_req1 got %0d exp 3", stat_cnt); end
    stat_sel = 2'd2; #1;
    checks++; if (stat_cnt !== 16'd1) begin failures++; $display("FAIL stats_req2 got %0d exp 1", stat_cnt); end
    stat_sel = 2'd0; #1;
    checks++; if (stat_cnt !== 16'd0) begin failures++; $display("FAIL stats_req0 got %0d exp 0", stat_cnt); end
`else
    issue(1, $urandom, rid, rs, ok);
    checks++; if (!ok || rid !== 2'd1) begin failures++; $display("FAIL stats_issue got ok=%0d id=%0d exp 1/1", ok, rid); end
    stat_sel = 2'd1; #1;
    checks++; if (stat_cnt !== 16'd0) begin failures++; $display("FAIL stats_tied got %0d exp 0", stat_cnt); end
`endif
    @(negedge clk);
  endtask

  // Transaction-level model: one outstanding request, ADD one cycle after
  // the grant, response from the following cycle until accepted.
  task automatic test_random;
    logic [DW-1:0] m_acc, op, exp_sum;
    logic [NR-1:0] gprev, exp_rdy;
    int            m_ptr, win, since, exp_id;
    bit            busy, ph_add, ph_resp;
    do_reset;
    m_acc = '0; m_ptr = NR - 1; busy = 1'b0; since = 0; exp_id = 0;
    exp_sum = '0; op = '0; gprev = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (gprev[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(2) == 0);
          bus.req_data[i*DW +: DW] = $urandom;
        end else if ($urandom_range(15) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.resp_ready = ($urandom_range(3) != 0);
      clear = ($urandom_range(7) == 0);
      #1;
      if (busy) since++;
      ph_add  = busy && since == 1;
      ph_resp = busy && since >= 2;
      checks++; if (accum_out !== m_acc) begin failures++; $display("FAIL rnd_accum @%0d got %0h exp %0h", cyc, accum_out, m_acc); end
      win = busy ? -1 : model_winner(bus.req_valid, m_ptr);
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rnd_grant @%0d got %b exp %b", cyc, bus.req_ready, exp_rdy); end
      checks++;
      if (ph_resp) begin
        if (bus.resp_valid !== 1'b1 || bus.resp_id !== IW'(exp_id) || bus.resp_sum !== exp_sum) begin failures++; $display("FAIL rnd_resp @%0d got v=%b id=%0d sum=%0h exp 1/%0d/%0h", cyc, bus.resp_valid, bus.resp_id, bus.resp_sum, exp_id, exp_sum); end
      end else if (bus.resp_valid !== 1'b0) begin
        failures++; $display("FAIL rnd_idle_resp @%0d got v=%b exp 0", cyc, bus.resp_valid);
      end
      if (ph_add) begin
        m_acc = (clear ? '0 : m_acc) + op;
        exp_sum = m_acc;
      end else if (clear) begin
        m_acc = '0;
      end
      if (ph_resp && bus.resp_ready) busy = 1'b0;
      if (win >= 0) begin
        busy = 1'b1; since = 0; exp_id = win; m_ptr = win;
        op = bus.req_data[win*DW +: DW];
      end
      gprev = bus.req_ready;
    end
    @(negedge clk);
    bus.req_valid = '0; clear = 1'b0; bus.resp_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; stat_sel = '0;
    bus.req_valid = '0; bus.req_data = '0; bus.resp_ready = 1'b1;
    test_reset;
    test_round_robin;
    test_wrap;
    test_clear;
    test_backpressure;
    test_reset_mid;
    test_stats;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_rr_sched.md
Name: accum_rr_sched

Overview:
- Shares one 32-bit accumulator among NUM_REQ requesters using round-robin arbitration.
- Each accepted request adds its operand to the shared running sum and returns the post-add sum, tagged with the requester ID, over a valid/ready response channel.
- Sits in front of the accumulator datapath and is the only block that sequences its updates.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, operand, accumulator and response width
ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden)

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
req_data  input  NUM_REQ*DATA_W  operands, requester i at bits [i*DATA_W +: DATA_W]
clear  input  1  synchronous accumulator clear pulse
resp_valid  output  1  response valid
resp_ready  input  1  response accept
resp_id  output  ID_W  ID of the requester being answered
resp_sum  output  DATA_W  accumulator value after that requester's add
accum_out  output  DATA_W  live accumulator value
stat_sel  input  ID_W  statistics counter select (optional feature)
stat_cnt  output  16  selected grant count (optional feature)

Behaviour:
- Reset (async assert, sync deassert in the system):
  - FSM enters IDLE; accumulator = 0; round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_sum = 0.
  - A reset mid-transaction drops any latched operand and any pending response.
- FSM states: IDLE -> ADD -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning upward from pointer+1, modulo NUM_REQ.
  - req_ready[winner] = 1 combinationally in this cycle only. The handshake completes this cycle.
  - Latch the operand and ID; set pointer = winner; go to ADD.
  - With no req_valid, stay in IDLE with req_ready = 0.
- ADD (1 cycle): accumulator <= accumulator + operand, modulo 2^DATA_W (carry discarded); go to RESP.
- RESP:
  - resp_valid = 1; resp_sum = accumulator; resp_id = latched ID. These hold stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE.
  - req_ready = 0 in ADD and in RESP.
- Throughput is 1 grant per 3 cycles when resp_ready is held at 1. Latency from grant to resp_valid is 2 cycles.
- Requester rules:
  - A requester must hold req_valid and req_data until it sees req_ready.
  - A requester that drops req_valid before being granted loses its turn with no side effects.
- Clear:
  - In IDLE or RESP: accumulator <= 0 next cycle. In RESP, resp_sum is unaffected because it comes from a separate registered copy captured at the end of ADD.
  - Coincident with ADD: clear applies first, so accumulator <= operand.
- accum_out always reflects the accumulator register.

Optional Feature:
- Macro: ACCUM_RR_SCHED_STATS_EN.
- Defined:
  - One 16-bit saturating grant counter per requester; it increments on the IDLE grant cycle and holds at 16'hFFFF.
  - Counters reset to 0 on rst_n only; clear does not affect them.
  - stat_cnt = counter[stat_sel], combinational. A stat_sel value >= NUM_REQ reads 0.
- Undefined: no counters are built, stat_cnt is tied to 0, and stat_sel is ignored. The port list is identical in both builds.

Decomposition:
- Package accum_rr_sched_pkg holds:
  - the state enum (S_IDLE, S_ADD, S_RESP), 2 bits;
  - STAT_W = 16;
  - function rr_pick(valid vector, pointer) returning the winner index and a found flag.
- Sub-module rr_arbiter holds the round-robin pointer register and the one-hot grant output, with an advance input pulsed on grant. The top level holds the FSM, the accumulator and the statistics.

Test Plan:
1. Reset with all req_valid = 0 -> req_ready = 0, resp_valid = 0, accum_out = 0. Then req_valid[2] = 1 with data 5 -> grant to 2; resp_id = 2 and resp_sum = 5 arrive 2 cycles later.
2. All four requesters valid continuously with data 1,2,3,4 and resp_ready = 1 -> grant order 0,1,2,3,0,...; resp_sum sequence 1,3,6,10,11; a new grant every 3 cycles.
3. Accumulator preloaded to 32'hFFFF_FFFE, add 3 -> resp_sum = 1 (wrap, carry discarded).
4. clear asserted in the ADD cycle of a request with data 7 while the accumulator is 100 -> resp_sum = 7. clear asserted in RESP after a sum of 7 -> resp_sum holds 7 and accum_out = 0 on the next cycle.
5. resp_ready held at 0 for 5 cycles -> resp_valid, resp_id and resp_sum stay stable, and no req_ready is raised; after release, the next grant occurs in the IDLE cycle that follows.
6. rst_n asserted during RESP -> outputs return to 0 at once, and requester 0 has priority after release. With ACCUM_RR_SCHED_STATS_EN defined, 3 grants to requester 1 -> stat_sel = 1 reads 3.
